// File: rtl/psum_row_collector_pkg.sv
// Shared types and constants for the psum row collector: FSM states,
// partial-sum width derivation and saturation limits.
package psum_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  function automatic int psum_width(input int matrix_size, input int input_width);
    return $clog2(matrix_size * (2 ** input_width)) - 1;
  endfunction

  // Clamp range for a signed INPUT_WIDTH+1 value
  function automatic int sat_max(input int input_width);
    return (2 ** input_width) - 1;
  endfunction

  function automatic int sat_min(input int input_width);
    return -(2 ** input_width);
  endfunction

  localparam int DEFAULT_INPUT_WIDTH = 8;
  localparam int DEFAULT_SAT_MAX     = sat_max(DEFAULT_INPUT_WIDTH);
  localparam int DEFAULT_SAT_MIN     = sat_min(DEFAULT_INPUT_WIDTH);

endpackage

// File: rtl/psum_row_collector_if.sv
// PE-side read handshake and downstream valid/ready stream of the collector.
interface psum_row_collector_if #(
  parameter int PSUM_WIDTH = 9
);
  logic                         PE_read_req;
  logic                         PE_read_ready;
  logic signed [PSUM_WIDTH-1:0] final_partialmul_in;
  logic signed [PSUM_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output PE_read_req, out_data, out_valid,
    input  PE_read_ready, final_partialmul_in, out_ready
  );

  modport slave (
    input  PE_read_req, out_data, out_valid,
    output PE_read_ready, final_partialmul_in, out_ready
  );
endinterface

// File: rtl/psum_row_collector_fifo.sv
// psum_fifo: synchronous FIFO with registered occupancy count; DEPTH must be
// a power of two so the pointers wrap naturally.
module psum_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/psum_row_collector.sv
// Right-edge drain for one systolic row: requests MATRIX_SIZE final sums from
// the last PE, buffers them and streams them out. Optional macro: PSUM_SAT_EN.
module psum_row_collector
  import psum_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int INPUT_WIDTH = 8,
  parameter int PSUM_WIDTH  = psum_width(MATRIX_SIZE, INPUT_WIDTH),
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  psum_row_collector_if.master   bus,
  output logic                   row_done,
  output logic                   busy
`ifdef PSUM_SAT_EN
  ,
  output logic                   sat_flag
`endif
);
  localparam int CW = $clog2(MATRIX_SIZE + 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic                    w_req;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_last;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_start_ok;
  logic [PSUM_WIDTH-1:0]   w_din;
  logic [PSUM_WIDTH-1:0]   w_dout;

  assign w_start_ok = (r_state == IDLE) && start;
  // Request is gated by the registered full flag, so a same-cycle pop cannot re-raise it
  assign w_req      = (r_state == COLLECT) && !w_full;
  assign w_push     = w_req && bus.PE_read_ready;
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_last     = (r_cnt == CW'(MATRIX_SIZE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    row_done    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_nxt = COLLECT;
      COLLECT: begin
        busy = 1'b1;
        if (w_push && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        row_done    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_cnt <= '0;
    else if (w_start_ok) r_cnt <= '0;
    else if (w_push)     r_cnt <= r_cnt + 1'b1;
  end

`ifdef PSUM_SAT_EN
  localparam int SAT_HI = sat_max(INPUT_WIDTH);
  localparam int SAT_LO = sat_min(INPUT_WIDTH);

  logic w_clamp_hi;
  logic w_clamp_lo;

  assign w_clamp_hi = int'(bus.final_partialmul_in) > SAT_HI;
  assign w_clamp_lo = int'(bus.final_partialmul_in) < SAT_LO;
  assign w_din      = w_clamp_hi ? PSUM_WIDTH'(SAT_HI) :
                      w_clamp_lo ? PSUM_WIDTH'(SAT_LO) : bus.final_partialmul_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                sat_flag <= 1'b0;
    else if (w_start_ok)                      sat_flag <= 1'b0;
    else if (w_push && (w_clamp_hi || w_clamp_lo)) sat_flag <= 1'b1;
  end
`else
  assign w_din = bus.final_partialmul_in;
`endif

  psum_fifo #(
    .WIDTH(PSUM_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_push),
    .i_data (w_din),
    .i_pop  (w_pop),
    .o_data (w_dout),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign bus.PE_read_req = w_req;
  assign bus.out_valid   = !w_empty;
  assign bus.out_data    = w_dout;
endmodule

// File: tb/tb_psum_row_collector.sv
// Directed scoreboard bench for psum_row_collector; a wide-sum, 2-deep
// instance covers back-pressure and (with PSUM_SAT_EN) clamping.
`timescale 1ns/1ps
module tb_psum_row_collector;
  localparam int W1 = 9;
  localparam int W2 = 12;
  localparam int D1 = 4;
  localparam int D2 = 2;

  logic clk = 1'b0;
  logic reset, start, start2;
  logic row_done, busy, row_done2, busy2;
`ifdef PSUM_SAT_EN
  logic sat_flag, sat_flag2;
`endif

  logic rdy1 = 1'b0, ordy1 = 1'b0, rand1 = 1'b0, rbit1 = 1'b0;
  logic rdy2 = 1'b0, ordy2 = 1'b0;
  logic signed [W1-1:0] d1 = '0;
  logic signed [W2-1:0] d2 = '0;
  logic signed [W1-1:0] src1[$], sb1[$];
  logic signed [W2-1:0] src2[$], sb2[$];
  int xfer1 = 0, xfer2 = 0, mcnt1 = 0, mcnt2 = 0;
  bit adv1 = 0, adv2 = 0;
  int n_cmp = 0, n_err = 0;
  int base;

  psum_row_collector_if #(.PSUM_WIDTH(W1)) bus1();
  psum_row_collector_if #(.PSUM_WIDTH(W2)) bus2();

  assign bus1.PE_read_ready       = rdy1;
  assign bus1.final_partialmul_in = d1;
  assign bus1.out_ready           = rand1 ? rbit1 : ordy1;
  assign bus2.PE_read_ready       = rdy2;
  assign bus2.final_partialmul_in = d2;
  assign bus2.out_ready           = ordy2;

  always #5 clk = ~clk;

  psum_row_collector #(.MATRIX_SIZE(3), .INPUT_WIDTH(8), .FIFO_DEPTH(D1)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus1),
    .row_done(row_done), .busy(busy)
`ifdef PSUM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  psum_row_collector #(.MATRIX_SIZE(3), .INPUT_WIDTH(8), .PSUM_WIDTH(W2), .FIFO_DEPTH(D2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bus(bus2),
    .row_done(row_done2), .busy(busy2)
`ifdef PSUM_SAT_EN
    , .sat_flag(sat_flag2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [W2-1:0] exp2(input logic signed [W2-1:0] v);
`ifdef PSUM_SAT_EN
    if (v > W2'(255))  return W2'(255);
    if (v < W2'(-256)) return W2'(-256);
`endif
    return v;
  endfunction

  // PE models + output scoreboards, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      sb1.delete(); mcnt1 = 0; adv1 = 0;
    end else begin
      check("valid1", 32'(bus1.out_valid), 32'(mcnt1 != 0));
      if (bus1.out_valid && bus1.out_ready) begin
        check("sb1_nonempty", 32'(sb1.size() != 0), 32'd1);
        if (sb1.size() != 0) check("out_data1", 32'(bus1.out_data), 32'(sb1.pop_front()));
        mcnt1--;
      end
      if (bus1.PE_read_req && bus1.PE_read_ready) begin
        sb1.push_back(d1); xfer1++; mcnt1++; adv1 = 1;
      end
      check("count1_bound", 32'(mcnt1 <= D1), 32'd1);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      sb2.delete(); mcnt2 = 0; adv2 = 0;
    end else begin
      check("valid2", 32'(bus2.out_valid), 32'(mcnt2 != 0));
      if (bus2.out_valid && bus2.out_ready) begin
        check("sb2_nonempty", 32'(sb2.size() != 0), 32'd1);
        if (sb2.size() != 0) check("out_data2", 32'(bus2.out_data), 32'(sb2.pop_front()));
        mcnt2--;
      end
      if (bus2.PE_read_req && bus2.PE_read_ready) begin
        sb2.push_back(exp2(d2)); xfer2++; mcnt2++; adv2 = 1;
      end
      check("count2_bound", 32'(mcnt2 <= D2), 32'd1);
    end
  end

  always @(posedge clk) begin
    #1;
    if (adv1 && src1.size() != 0) void'(src1.pop_front());
    if (adv2 && src2.size() != 0) void'(src2.pop_front());
    adv1 = 0; adv2 = 0;
    d1 = (src1.size() != 0) ? src1[0] : '0;
    d2 = (src2.size() != 0) ? src2[0] : '0;
    rbit1 = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit second, input int lim);
    int k = 0;
    while (((second ? row_done2 : row_done) !== 1'b1) && k < lim) begin tick(); k++; end
    check(second ? "row_done2_seen" : "row_done1_seen", 32'(second ? row_done2 : row_done), 32'd1);
  endtask

  task automatic drain(input bit second, input int lim);
    int k = 0;
    if (second) ordy2 = 1'b1; else ordy1 = 1'b1;
    while (((second ? sb2.size() : sb1.size()) != 0) && k < lim) begin tick(); k++; end
    check(second ? "drain2" : "drain1", 32'(second ? sb2.size() : sb1.size()), 32'd0);
  endtask

  task automatic pulse_start(input bit second);
    if (second) start2 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",      32'(bus1.PE_read_req), 32'd0);
    check("rst_valid",    32'(bus1.out_valid),   32'd0);
    check("rst_data",     32'(bus1.out_data),    32'd0);
    check("rst_row_done", 32'(row_done),         32'd0);
    check("rst_busy",     32'(busy),             32'd0);
`ifdef PSUM_SAT_EN
    check("rst_sat", 32'(sat_flag), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Basic row at full rate: 5, -7, 100
    src1.push_back(W1'(5)); src1.push_back(W1'(-7)); src1.push_back(W1'(100));
    rdy1 = 1'b1; ordy1 = 1'b1; base = xfer1;
    tick();
    pulse_start(0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_req",  32'(bus1.PE_read_req), 32'd1);
    tick();
    check("lat_valid", 32'(bus1.out_valid), 32'd1);
    check("lat_data",  32'(bus1.out_data),  32'(W1'(5)));
    tick(); tick();
    check("done_pulse", 32'(row_done), 32'd1);
    check("done_req",   32'(bus1.PE_read_req), 32'd0);
    check("done_busy",  32'(busy), 32'd0);
    check("row_xfers",  32'(xfer1 - base), 32'd3);
    tick();
    check("done_clear", 32'(row_done), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    rdy1 = 1'b0;
    drain(0, 20);

    // Back-pressure on the 2-deep instance
    src2.push_back(W2'(11)); src2.push_back(W2'(22)); src2.push_back(W2'(33));
    rdy2 = 1'b1; ordy2 = 1'b0; base = xfer2;
    tick();
    pulse_start(1);
    tick(); tick(); tick(); tick();
    check("full_req",   32'(bus2.PE_read_req), 32'd0);
    check("full_xfers", 32'(xfer2 - base), 32'd2);
    check("full_busy",  32'(busy2), 32'd1);
    ordy2 = 1'b1; #1;
    check("pop_no_rereq", 32'(bus2.PE_read_req), 32'd0);
    tick();
    ordy2 = 1'b0;
    check("rereq", 32'(bus2.PE_read_req), 32'd1);
    tick();
    check("bp_done",  32'(row_done2), 32'd1);
    check("bp_xfers", 32'(xfer2 - base), 32'd3);
    rdy2 = 1'b0;
    drain(1, 20);

    // Ten back-to-back rows with random downstream stalls
    for (int i = 0; i < 30; i++) src1.push_back(W1'($urandom_range(0, 511)));
    rdy1 = 1'b1; rand1 = 1'b1; base = xfer1;
    tick();
    for (int r = 0; r < 10; r++) begin
      tick();
      pulse_start(0);
      wait_done(0, 100);
    end
    rand1 = 1'b0;
    drain(0, 100);
    check("stream_xfers", 32'(xfer1 - base), 32'd30);
    rdy1 = 1'b0;

    // Reset in the middle of a row
    src1.push_back(W1'(1)); src1.push_back(W1'(2)); src1.push_back(W1'(3));
    rdy1 = 1'b1; ordy1 = 1'b0;
    tick();
    pulse_start(0);
    tick(); tick();
    reset = 1'b1; #1;
    check("mid_rst_req",   32'(bus1.PE_read_req), 32'd0);
    check("mid_rst_valid", 32'(bus1.out_valid),   32'd0);
    check("mid_rst_data",  32'(bus1.out_data),    32'd0);
    check("mid_rst_busy",  32'(busy),             32'd0);
    src1.delete();
    tick();
    reset = 1'b0;
    src1.push_back(W1'(7)); src1.push_back(W1'(8)); src1.push_back(W1'(9));
    ordy1 = 1'b1; base = xfer1;
    tick();
    pulse_start(0);
    wait_done(0, 20);
    check("fresh_xfers", 32'(xfer1 - base), 32'd3);
    drain(0, 20);

    // Ready in IDLE and start during COLLECT are ignored
    src1.delete(); src1.push_back(W1'(99));
    rdy1 = 1'b1; ordy1 = 1'b1; base = xfer1;
    repeat (4) tick();
    check("idle_xfers", 32'(xfer1 - base), 32'd0);
    check("idle_valid", 32'(bus1.out_valid), 32'd0);
    check("idle_req",   32'(bus1.PE_read_req), 32'd0);
    rdy1 = 1'b0;
    src1.delete(); src1.push_back(W1'(4)); src1.push_back(W1'(5)); src1.push_back(W1'(6));
    tick();
    pulse_start(0);
    tick();
    pulse_start(0);
    check("restart_busy",  32'(busy), 32'd1);
    check("restart_xfers", 32'(xfer1 - base), 32'd0);
    rdy1 = 1'b1;
    wait_done(0, 20);
    check("restart_row", 32'(xfer1 - base), 32'd3);
    tick(); tick();
    check("no_queued_start", 32'(busy), 32'd0);
    rdy1 = 1'b0;
    drain(0, 20);

    // Out-of-range sums: clamped with PSUM_SAT_EN, bit-exact otherwise
    src2.push_back(W2'(300)); src2.push_back(W2'(-300)); src2.push_back(W2'(17));
    rdy2 = 1'b1; ordy2 = 1'b1;
    tick();
    pulse_start(1);
    wait_done(1, 20);
`ifdef PSUM_SAT_EN
    check("sat_set", 32'(sat_flag2), 32'd1);
    check("sat_other_clear", 32'(sat_flag), 32'd0);
`endif
    drain(1, 20);
    src2.push_back(W2'(1)); src2.push_back(W2'(2)); src2.push_back(W2'(3));
    tick();
    pulse_start(1);
`ifdef PSUM_SAT_EN
    check("sat_cleared", 32'(sat_flag2), 32'd0);
`endif
    wait_done(1, 20);
    drain(1, 20);
    rdy2 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
